// File: rtl/sram_burst_arbiter.sv
// sram_burst_arbiter
// Two-port round-robin burst arbiter and address sequencer for a single-port
// scratch SRAM (combinational read, write committed on the rising edge).
// One client owns the SRAM at a time. One beat is issued per cycle from the
// latched base address. The address wraps modulo the SRAM depth.

module sram_burst_arbiter #(
  parameter int A = 7,   // SRAM address width, depth = 2**A words
  parameter int W = 16   // SRAM word width
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       req,
  input  logic [1:0]       we,
  input  logic [2*A-1:0]   base,
  input  logic [2*A-1:0]   len,
  input  logic [2*W-1:0]   wdata,
  output logic [1:0]       grant,
  output logic [1:0]       wr_ready,
  output logic [W-1:0]     rd_data,
  output logic [1:0]       rd_valid,
  output logic [1:0]       done,
  output logic             busy,
  output logic [A-1:0]     sram_address,
  output logic [W-1:0]     sram_dataInput,
  output logic             sram_write,
  input  logic [W-1:0]     sram_dataOutput
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t         state;
  logic           owner;        // port that owns the current burst
  logic           last_served;  // port granted most recently
  logic           b_we;         // latched direction of the current burst
  logic [A-1:0]   b_len;        // latched burst length minus one
  logic [A-1:0]   idx;          // beat counter, 0..b_len
  logic [A-1:0]   cur_addr;     // address of the current beat; holds in IDLE
  logic           win;          // arbitration winner for this cycle
  logic [W-1:0]   owner_wdata;  // write data of the owning port
  logic           wr_beat;      // a write beat is being issued this cycle

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves win unassigned and no latch is inferred.
    win = 1'b0;
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_served;
      default: win = 1'b0;
    endcase
  end

  // Burst FSM: arbitrate in IDLE, step one beat per cycle in BURST, register all pulses.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    if (RST) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;   // favours port 0 after reset
      b_we        <= 1'b0;
      b_len       <= '0;
      idx         <= '0;
      cur_addr    <= '0;
      grant       <= 2'b00;
      rd_data     <= '0;
      rd_valid    <= 2'b00;
      done        <= 2'b00;
    end else begin
      grant    <= 2'b00;
      rd_valid <= 2'b00;
      done     <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|req) begin
            state       <= BURST;
            owner       <= win;
            last_served <= win;
            b_we        <= we[win];
            b_len       <= len[win*A +: A];
            idx         <= '0;
            cur_addr    <= base[win*A +: A];
            grant       <= 2'b01 << win;
          end
        end
        BURST: begin
          // Read beats capture the combinational SRAM output for the next cycle.
          if (!b_we) begin
            rd_data  <= sram_dataOutput;
            rd_valid <= 2'b01 << owner;
          end
          if (idx == b_len) begin
            state <= IDLE;
            done  <= 2'b01 << owner;
          end else begin
            idx      <= idx + 1'b1;
            cur_addr <= cur_addr + 1'b1;   // natural wrap at 2**A
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM side is decoded straight from the state registers.
  assign busy           = (state == BURST);
  assign wr_beat        = busy & b_we;
  assign owner_wdata    = wdata[owner*W +: W];
  assign sram_address   = cur_addr;
  // A beat that coincides with reset must not commit, so the strobe is gated by RST.
  assign sram_write     = wr_beat & ~RST;
  assign sram_dataInput = wr_beat ? owner_wdata : '0;
  assign wr_ready       = wr_beat ? (2'b01 << owner) : 2'b00;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Bench for sram_burst_arbiter: a bench-side SRAM, a burst-schedule model
// that checks every cycle, and literal expectations for the directed scenarios.

module tb_sram_burst_arbiter;

  localparam int A  = 7;
  localparam int W  = 16;
  localparam int D  = 1 << A;
  localparam int NC = 4096;

  logic           CLK = 1'b0;
  logic           RST;
  logic [1:0]     req, we;
  logic [2*A-1:0] base, len;
  logic [2*W-1:0] wdata;
  logic [1:0]     grant, wr_ready, rd_valid, done;
  logic [W-1:0]   rd_data;
  logic           busy;
  logic [A-1:0]   sram_address;
  logic [W-1:0]   sram_dataInput;
  logic           sram_write;
  logic [W-1:0]   sram_dataOutput;

  always #5 CLK = ~CLK;

  sram_burst_arbiter #(.A(A), .W(W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .base(base), .len(len),
    .wdata(wdata), .grant(grant), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .busy(busy),
    .sram_address(sram_address), .sram_dataInput(sram_dataInput),
    .sram_write(sram_write), .sram_dataOutput(sram_dataOutput)
  );

  // Scratch SRAM: combinational read, write on the rising edge.
  logic [W-1:0] mem [D];
  logic         mem_init = 1'b1;
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < D; i++) mem[i] <= W'(16'h5000 + i);
    end else if (sram_write === 1'b1) begin
      mem[sram_address] <= sram_dataInput;
    end
  end
  assign sram_dataOutput = mem[sram_address];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Client descriptors, owned by the stimulus process.
  logic [A-1:0] d_base [2];
  logic [A-1:0] d_len  [2];
  logic         d_we   [2];
  logic [W-1:0] d_data [2][D];
  int           req_total [2];
  int           rst_cycle = -1;
  logic         init_rst  = 1'b1;

  // Model: per-cycle expected schedule derived from the burst timing rules.
  bit [1:0]     p_grant [NC];
  bit [1:0]     p_wrr   [NC];
  bit [1:0]     p_rdv   [NC];
  bit [1:0]     p_done  [NC];
  bit           p_busy  [NC];
  bit           p_write [NC];
  bit [A-1:0]   p_addr  [NC];
  bit [A-1:0]   p_raddr [NC];
  bit [W-1:0]   p_din   [NC];
  bit [W-1:0]   mmem    [D];
  int           granted [2];
  int           free_cycle  = 0;
  bit           last_port   = 1'b1;
  bit [A-1:0]   hold        = '0;
  bit           model_valid = 1'b0;

  // Observed DUT events for the literal checks.
  int           g_cyc[$], g_port[$], d_cyc[$], d_port[$], r_cyc[$], r_port[$];
  logic [W-1:0] r_data[$];

  // Schedule one whole burst accepted in idle cycle t.
  task automatic plan(input int t);
    int         win, ln;
    logic [A-1:0] b;
    logic       w;
    if (req == 2'b11) win = last_port ? 0 : 1;
    else              win = req[1] ? 1 : 0;
    last_port = win[0];
    granted[win]++;
    b  = base[win*A +: A];
    ln = int'(len[win*A +: A]) + 1;
    w  = we[win];
    p_grant[t+1][win] = 1'b1;
    for (int i = 0; i < ln; i++) begin
      int c;
      c = t + 1 + i;
      p_busy[c] = 1'b1;
      p_addr[c] = A'((int'(b) + i) % D);
      if (w) begin
        p_write[c]     = 1'b1;
        p_din[c]       = d_data[win][i];
        p_wrr[c][win]  = 1'b1;
      end else begin
        p_rdv[c+1][win] = 1'b1;
        p_raddr[c+1]    = p_addr[c];
      end
    end
    p_done[t+ln+1][win] = 1'b1;
    free_cycle = t + ln + 1;
    hold       = A'((int'(b) + ln - 1) % D);
  endtask

  task automatic cmp(input int k);
    string s;
    s = $sformatf("c%0d", k);
    check({s, " busy"},     busy,         p_busy[k]);
    check({s, " grant"},    grant,        p_grant[k]);
    check({s, " wr_ready"}, wr_ready,     p_wrr[k]);
    check({s, " rd_valid"}, rd_valid,     p_rdv[k]);
    check({s, " done"},     done,         p_done[k]);
    check({s, " write"},    sram_write,   p_write[k] & ~RST);
    check({s, " address"},  sram_address, p_busy[k] ? p_addr[k] : hold);
    if (!p_busy[k] || p_write[k])
      check({s, " dataInput"}, sram_dataInput, p_write[k] ? p_din[k] : '0);
    if (p_rdv[k] != 2'b00)
      check({s, " rd_data"}, rd_data, mmem[p_raddr[k]]);
  endtask

  // Compare process: check, log, commit modelled writes, then arbitrate.
  always @(negedge CLK) begin : model_blk
    int k;
    k = cyc;
    if (model_valid) begin
      cmp(k);
      for (int p = 0; p < 2; p++) begin
        if (grant[p] === 1'b1)    begin g_cyc.push_back(k); g_port.push_back(p); end
        if (done[p] === 1'b1)     begin d_cyc.push_back(k); d_port.push_back(p); end
        if (rd_valid[p] === 1'b1) begin r_cyc.push_back(k); r_port.push_back(p); r_data.push_back(rd_data); end
      end
      if (p_write[k] && RST === 1'b0) mmem[p_addr[k]] = p_din[k];
    end
    if (RST === 1'b1) begin
      if (!model_valid)
        for (int i = 0; i < D; i++) mmem[i] = W'(16'h5000 + i);
      for (int c = k + 1; c <= k + 200 && c < NC; c++) begin
        p_grant[c] = '0; p_wrr[c] = '0; p_rdv[c] = '0; p_done[c] = '0;
        p_busy[c] = 1'b0; p_write[c] = 1'b0;
      end
      free_cycle  = k + 1;
      last_port   = 1'b1;
      hold        = '0;
      model_valid = 1'b1;
    end else if (model_valid && k >= free_cycle && req != 2'b00) begin
      plan(k);
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    mem_init = 1'b0;
    RST = init_rst || (cyc == rst_cycle);
    for (int p = 0; p < 2; p++) begin
      req[p] = (req_total[p] > granted[p]);
      if (cyc >= free_cycle) begin
        base[p*A +: A] = d_base[p];
        len[p*A +: A]  = d_len[p];
        we[p]          = d_we[p];
      end else begin
        base[p*A +: A] = A'($urandom);
        len[p*A +: A]  = A'($urandom);
        we[p]          = 1'($urandom);
      end
      wdata[p*W +: W] = p_wrr[cyc][p] ? p_din[cyc] : W'($urandom);
    end
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((req_total[0] != granted[0] || req_total[1] != granted[1] ||
                cyc <= free_cycle + 1) && n < 400);
    if (n >= 400) check("run_idle timeout", 1, 0);
  endtask

  task automatic set_port(input int p, input int b, input int l, input bit w, input int d0);
    d_base[p] = A'(b);
    d_len[p]  = A'(l);
    d_we[p]   = w;
    for (int i = 0; i < D; i++) d_data[p][i] = W'(d0 + i);
  endtask

  // Read beats of a port in [from, upto]: n of them at consecutive cycles from c0, values v0, v0+1, ...
  task automatic check_rd(input string name, input int port, input int from, input int upto,
                          input int c0, input int n, input int v0);
    int seen;
    seen = 0;
    foreach (r_cyc[i]) begin
      if (r_port[i] == port && r_cyc[i] >= from && r_cyc[i] <= upto) begin
        if (seen < n) begin
          check($sformatf("%s rd%0d data", name, seen), r_data[i], v0 + seen);
          check($sformatf("%s rd%0d cycle", name, seen), r_cyc[i], c0 + seen);
        end
        seen++;
      end
    end
    check({name, " rd count"}, seen, n);
  endtask

  // Done pulses of a port from cycle 'from': exactly one at exp_c, or none when exp_c < 0.
  task automatic check_done(input string name, input int port, input int from, input int exp_c);
    int seen, at;
    seen = 0;
    at   = -1;
    foreach (d_cyc[i]) begin
      if (d_port[i] == port && d_cyc[i] >= from) begin
        seen++;
        at = d_cyc[i];
      end
    end
    check({name, " done count"}, seen, (exp_c < 0) ? 0 : 1);
    if (exp_c >= 0) check({name, " done cycle"}, at, exp_c);
  endtask

  task automatic do_reset();
    init_rst = 1'b1;
    step();
    step();
    init_rst = 1'b0;
  endtask

  int t;

  initial begin
    RST = 1'b1; req = '0; we = '0; base = '0; len = '0; wdata = '0;
    req_total[0] = 0; req_total[1] = 0;
    set_port(0, 0, 0, 1'b0, 0);
    set_port(1, 0, 0, 1'b0, 0);
    repeat (3) step();
    init_rst = 1'b0;
    step();

    // Reset values.
    check("reset grant",    grant,        2'b00);
    check("reset busy",     busy,         1'b0);
    check("reset rd_data",  rd_data,      '0);
    check("reset rd_valid", rd_valid,     2'b00);
    check("reset done",     done,         2'b00);
    check("reset address",  sram_address, '0);
    check("reset write",    sram_write,   1'b0);

    // Port 0 writes 5..8, port 1 reads them back.
    set_port(0, 5, 3, 1'b1, 'hA0);
    t = cyc + 1;
    req_total[0]++;
    run_idle();
    for (int i = 0; i < 4; i++) check($sformatf("wr mem[%0d]", 5 + i), mem[5+i], 'hA0 + i);
    check("wr grant cycle", (g_cyc.size() > 0) ? g_cyc[g_cyc.size()-1] - t : -1, 1);
    check_done("wr", 0, t, t + 5);
    set_port(1, 5, 3, 1'b0, 0);
    t = cyc + 1;
    req_total[1]++;
    run_idle();
    check_rd("rd", 1, t, t + 10, t + 2, 4, 'hA0);
    check_done("rd", 1, t, t + 5);

    // Contention straight after reset: grants alternate 0,1,0,1 with one idle cycle between bursts.
    do_reset();
    set_port(0, 20, 1, 1'b1, 'hB0);
    set_port(1, 20, 2, 1'b0, 0);
    t = cyc + 1;
    req_total[0] += 2;
    req_total[1] += 2;
    begin
      int g0;
      g0 = g_cyc.size();
      run_idle();
      check("contention grant count", g_cyc.size() - g0, 4);
      for (int i = 0; i < 4 && g0 + i < g_cyc.size(); i++) begin
        int exp_c [4];
        exp_c = '{1, 4, 8, 11};
        check($sformatf("contention grant%0d port", i),  g_port[g0+i], i % 2);
        check($sformatf("contention grant%0d cycle", i), g_cyc[g0+i] - t, exp_c[i]);
      end
    end
    check_rd("contention", 1, t + 5, t + 6, t + 5, 2, 'hB0);
    check_rd("contention tail", 1, t + 7, t + 7, t + 7, 1, 'h5016);

    // Wrap-around write then readback.
    set_port(0, 126, 3, 1'b1, 'hC0);
    t = cyc + 1;
    req_total[0]++;
    run_idle();
    check("wrap mem[126]", mem[126], 'hC0);
    check("wrap mem[127]", mem[127], 'hC1);
    check("wrap mem[0]",   mem[0],   'hC2);
    check("wrap mem[1]",   mem[1],   'hC3);
    set_port(1, 126, 3, 1'b0, 0);
    t = cyc + 1;
    req_total[1]++;
    run_idle();
    check_rd("wrap", 1, t, t + 10, t + 2, 4, 'hC0);

    // Full-depth write of 128 beats.
    set_port(1, 64, 127, 1'b1, 'h1000);
    t = cyc + 1;
    req_total[1]++;
    run_idle();
    check_done("full", 1, t, t + 129);
    for (int i = 0; i < D; i++)
      check($sformatf("full mem[%0d]", (64 + i) % D), mem[(64 + i) % D], 'h1000 + i);

    // Reset during beat 2 of a 6-beat write: beats 0 and 1 only.
    set_port(0, 10, 5, 1'b1, 'hE0);
    t = cyc + 1;
    rst_cycle = t + 3;
    req_total[0]++;
    run_idle();
    rst_cycle = -1;
    step();
    check("abort mem[10]", mem[10], 'hE0);
    check("abort mem[11]", mem[11], 'hE1);
    check("abort mem[12]", mem[12], 'h104C);
    check("abort mem[13]", mem[13], 'h104D);
    check_done("abort", 0, t, -1);

    // Read burst with base/len/we scrambled while it runs.
    set_port(1, 100, 4, 1'b0, 0);
    t = cyc + 1;
    req_total[1]++;
    run_idle();
    check_rd("ignore", 1, t, t + 12, t + 2, 5, 'h1024);
    check_done("ignore", 1, t, t + 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
